branch_dispatch_queue: RTL and testbench

- Receiving end of the B-format decoder output interface.
- Accepts decoded B-form branch ops (bc/bca/bcl/bcla) from the decoder, resolves target and link addresses, buffers them in a small in-order FIFO and presents them to the branch unit with a valid/ready handshake.
- Drives stall_o back to the decoder when the buffer cannot accept.

---
 rtl/branch_dispatch_queue_pkg.sv | 64 ++++++
 rtl/branch_dispatch_queue_if.sv | 52 +++++
 rtl/branch_dispatch_queue_target_calc.sv | 33 +++
 rtl/branch_dispatch_queue.sv | 116 +++++++++++
 tb/tb_branch_dispatch_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_dispatch_queue_pkg.sv
// Shared decode definitions: unit codes, B-form field offsets, format codes, queue entry layout.
// No logic; pure types and constants.
// Imported by the interface, the target calculator and the queue top.
package branch_dispatch_queue_pkg;

  localparam int addressWidth            = 64;
  localparam int opcodeSize              = 12;
  localparam int PrimOpcodeSize          = 6;
  localparam int funcUnitCodeSize        = 3;
  localparam int instructionCounterWidth = 64;
  localparam int instMinIdWidth          = 7;
  localparam int PidSize                 = 20;
  localparam int TidSize                 = 16;
  localparam int bodyWidth               = 28;
  localparam int queueDepth              = 4;
  localparam int countWidth              = $clog2(queueDepth) + 1;
  localparam int ptrWidth                = $clog2(queueDepth);

  // Functional unit codes carried alongside each decoded op
  localparam logic [funcUnitCodeSize-1:0] FXUnitId     = 3'd0;
  localparam logic [funcUnitCodeSize-1:0] FPUnitId     = 3'd1;
  localparam logic [funcUnitCodeSize-1:0] VXUnitId     = 3'd2;
  localparam logic [funcUnitCodeSize-1:0] CRUnitId     = 3'd3;
  localparam logic [funcUnitCodeSize-1:0] LSUnitId     = 3'd4;
  localparam logic [funcUnitCodeSize-1:0] BranchUnitID = 3'd6;

  // B-form body layout, bit 0 is the most significant bit of the body
  localparam int BO_POS = 0;
  localparam int BO_W   = 5;
  localparam int BI_POS = 5;
  localparam int BI_W   = 5;
  localparam int BD_POS = 10;
  localparam int BD_W   = 14;
  localparam int AA_POS = 24;
  localparam int LK_POS = 25;

  // Decoder output format selectors (one-hot)
  localparam logic [5:0] FMT_I  = 6'b000001;
  localparam logic [5:0] FMT_B  = 6'b000010;
  localparam logic [5:0] FMT_SC = 6'b000100;
  localparam logic [5:0] FMT_D  = 6'b001000;
  localparam logic [5:0] FMT_X  = 6'b010000;
  localparam logic [5:0] FMT_XL = 6'b100000;

  // One buffered branch op, targets already resolved
  typedef struct packed {
    logic [opcodeSize-1:0]            opcode;
    logic [BO_W-1:0]                  bo;
    logic [BI_W-1:0]                  bi;
    logic [addressWidth-1:0]          target;
    logic [addressWidth-1:0]          link;
    logic                             lk;
    logic [instructionCounterWidth:0] maj_id;
    logic [instMinIdWidth-1:0]        min_id;
    logic [PidSize-1:0]               pid;
    logic [TidSize-1:0]               tid;
  } entry_t;

  // Word displacement: BD||00, sign-extended to a full address
  function automatic logic [addressWidth-1:0] bd_disp(input logic [BD_W-1:0] bd);
    return {{(addressWidth-BD_W-2){bd[BD_W-1]}}, bd, 2'b00};
  endfunction

endpackage

// File: rtl/branch_dispatch_queue_if.sv
// Decoder-to-queue and queue-to-branch-unit signal bundle.
// No latency; wiring only.
// stall_o throttles the decoder, valid_o/ready_i handshake with the branch unit.
interface branch_dispatch_queue_if;
  import branch_dispatch_queue_pkg::*;

  // decoder side
  logic                             enable_i;
  logic [opcodeSize-1:0]            opcode_i;
  logic [addressWidth-1:0]          instructionAddress_i;
  logic [funcUnitCodeSize-1:0]      functionalUnitType_i;
  logic [0:instructionCounterWidth] instMajId_i;
  logic [instMinIdWidth-1:0]        instMinId_i;
  logic                             is64Bit_i;
  logic [PidSize-1:0]               instPid_i;
  logic [TidSize-1:0]               instTid_i;
  logic [0:bodyWidth-1]             instructionBody_i;
  logic                             stall_o;

  // branch unit side
  logic                             valid_o;
  logic                             ready_i;
  logic [opcodeSize-1:0]            opcode_o;
  logic [4:0]                       bo_o;
  logic [4:0]                       bi_o;
  logic [addressWidth-1:0]          target_o;
  logic [addressWidth-1:0]          link_o;
  logic                             lk_o;
  logic [0:instructionCounterWidth] instMajId_o;
  logic [instMinIdWidth-1:0]        instMinId_o;
  logic [PidSize-1:0]               instPid_o;
  logic [TidSize-1:0]               instTid_o;
  logic                             overflow_o;
  logic [countWidth-1:0]            count_o;

  // queue view
  modport slave (
    input  enable_i, opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, is64Bit_i, instPid_i, instTid_i, instructionBody_i, ready_i,
    output stall_o, valid_o, opcode_o, bo_o, bi_o, target_o, link_o, lk_o, instMajId_o,
           instMinId_o, instPid_o, instTid_o, overflow_o, count_o
  );

  // decoder + branch unit view
  modport master (
    output enable_i, opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, is64Bit_i, instPid_i, instTid_i, instructionBody_i, ready_i,
    input  stall_o, valid_o, opcode_o, bo_o, bi_o, target_o, link_o, lk_o, instMajId_o,
           instMinId_o, instPid_o, instTid_o, overflow_o, count_o
  );

endinterface

// File: rtl/branch_dispatch_queue_target_calc.sv
// Resolves B-form branch target and link address from CIA, BD and AA.
// Combinational, zero latency.
// No backpressure; pure function of its inputs.
module branch_target_calc
  import branch_dispatch_queue_pkg::*;
(
  input  logic [addressWidth-1:0] address,
  input  logic [BD_W-1:0]         bd,
  input  logic                    aa,
  input  logic                    is64,
  output logic [addressWidth-1:0] target,
  output logic [addressWidth-1:0] link
);

  logic [addressWidth-1:0] disp;
  logic [addressWidth-1:0] raw_target;
  logic [addressWidth-1:0] raw_link;
  logic [addressWidth-1:0] mode_mask;

  assign disp = bd_disp(bd);

  // absolute branches ignore the CIA; relative ones wrap modulo 2^addressWidth
  always_comb begin
    raw_target = aa ? disp : address + disp;
    raw_link   = address + addressWidth'(4);
  end

  // 32-bit mode keeps only the low word of both results
  assign mode_mask = {{(addressWidth-32){is64}}, {32{1'b1}}};
  assign target    = raw_target & mode_mask;
  assign link      = raw_link & mode_mask;

endmodule

// File: rtl/branch_dispatch_queue.sv
// In-order FIFO of decoded B-form branch ops feeding the branch unit, show-ahead head.
// Latency: op pushed at edge N appears on valid_o right after edge N.
// Backpressure: stall_o while full; branch ops offered while full are dropped and flag overflow_o.
module branch_dispatch_queue
  import branch_dispatch_queue_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  branch_dispatch_queue_if.slave bus
);

  logic [ptrWidth-1:0]     rd_ptr;
  logic [ptrWidth-1:0]     wr_ptr;
  logic [countWidth-1:0]   count;
  logic                    overflow;
  entry_t                  mem [queueDepth];
  entry_t                  wr_entry;
  entry_t                  head;
  logic                    is_branch;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [addressWidth-1:0] target;
  logic [addressWidth-1:0] link;
  logic                    unused_body_bits;

  assign is_branch = bus.enable_i && (bus.functionalUnitType_i == BranchUnitID);
  assign full      = (count == countWidth'(queueDepth));
  assign empty     = (count == '0);
  // push decision uses the pre-edge count, so a pop while full never frees a slot this cycle
  assign push      = is_branch && !full;
  assign pop       = !empty && bus.ready_i;

  // body bits 26:27 are reserved zero in B-form
  assign unused_body_bits = ^bus.instructionBody_i[26:27];

  branch_target_calc u_target_calc (
    .address (bus.instructionAddress_i),
    .bd      (bus.instructionBody_i[BD_POS +: BD_W]),
    .aa      (bus.instructionBody_i[AA_POS]),
    .is64    (bus.is64Bit_i),
    .target  (target),
    .link    (link)
  );

  // assemble the entry written at the tail
  always_comb begin
    wr_entry        = '0;
    wr_entry.opcode = bus.opcode_i;
    wr_entry.bo     = bus.instructionBody_i[BO_POS +: BO_W];
    wr_entry.bi     = bus.instructionBody_i[BI_POS +: BI_W];
    wr_entry.target = target;
    wr_entry.link   = link;
    wr_entry.lk     = bus.instructionBody_i[LK_POS];
    wr_entry.maj_id = bus.instMajId_i;
    wr_entry.min_id = bus.instMinId_i;
    wr_entry.pid    = bus.instPid_i;
    wr_entry.tid    = bus.instTid_i;
  end

  // storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // pointers and occupancy; pointers wrap naturally at queueDepth
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + ptrWidth'(1);
      case ({push, pop})
        2'b10:   count <= count + countWidth'(1);
        2'b01:   count <= count - countWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky record of a branch op lost to a full queue
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow <= 1'b0;
    end else if (is_branch && full) begin
      overflow <= 1'b1;
    end
  end

  // show-ahead head, forced to zero when nothing is queued
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign bus.stall_o     = full;
  assign bus.valid_o     = !empty;
  assign bus.opcode_o    = head.opcode;
  assign bus.bo_o        = head.bo;
  assign bus.bi_o        = head.bi;
  assign bus.target_o    = head.target;
  assign bus.link_o      = head.link;
  assign bus.lk_o        = head.lk;
  assign bus.instMajId_o = head.maj_id;
  assign bus.instMinId_o = head.min_id;
  assign bus.instPid_o   = head.pid;
  assign bus.instTid_o   = head.tid;
  assign bus.overflow_o  = overflow;
  assign bus.count_o     = count;

endmodule

// File: tb/tb_branch_dispatch_queue.sv
// Directed bench for branch_dispatch_queue with a scoreboard of expected pops.
// Stimulus drives #1 after each rising edge; the monitor samples on falling edges.
// Expected targets/links are hand-computed constants or simple address rules.
module tb_branch_dispatch_queue;
  import branch_dispatch_queue_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  entry_t exp_q[$];

  branch_dispatch_queue_if bif();

  branch_dispatch_queue dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [63:0] cia, input logic [13:0] bd,
                      input logic aa, input logic lk, input logic is64,
                      input logic [2:0] unit, input logic [63:0] tgt,
                      input logic [63:0] lnk, input bit exp_push);
    entry_t e;
    e.opcode = 12'h040 + 12'(id);
    e.bo     = 5'h14 ^ 5'(id);
    e.bi     = 5'(id);
    e.target = tgt;
    e.link   = lnk;
    e.lk     = lk;
    e.maj_id = {1'b1, 64'(id)};
    e.min_id = 7'(id);
    e.pid    = 20'h00100 + 20'(id);
    e.tid    = 16'h0055 + 16'(id);
    bif.enable_i             = 1'b1;
    bif.opcode_i             = e.opcode;
    bif.instructionAddress_i = cia;
    bif.functionalUnitType_i = unit;
    bif.instMajId_i          = e.maj_id;
    bif.instMinId_i          = e.min_id;
    bif.is64Bit_i            = is64;
    bif.instPid_i            = e.pid;
    bif.instTid_i            = e.tid;
    bif.instructionBody_i    = {e.bo, e.bi, bd, aa, lk, 2'b00};
    if (exp_push) exp_q.push_back(e);
    tick();
  endtask

  // scoreboard monitor: every accepted head must match the next expected op
  always @(negedge clk) begin
    if (rst_n && bif.valid_o && bif.ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got valid head id %0d, required no entry", bif.instMinId_o);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("opcode", 64'(bif.opcode_o), 64'(e.opcode));
        check("bo", 64'(bif.bo_o), 64'(e.bo));
        check("bi", 64'(bif.bi_o), 64'(e.bi));
        check("target", bif.target_o, e.target);
        check("link", bif.link_o, e.link);
        check("lk", 64'(bif.lk_o), 64'(e.lk));
        check("maj_hi", 64'(bif.instMajId_o[0]), 64'(e.maj_id[64]));
        check("maj_lo", bif.instMajId_o[1:64], e.maj_id[63:0]);
        check("min_id", 64'(bif.instMinId_o), 64'(e.min_id));
        check("pid", 64'(bif.instPid_o), 64'(e.pid));
        check("tid", 64'(bif.instTid_o), 64'(e.tid));
      end
    end
  end

  initial begin
    rst_n                    = 1'b0;
    bif.enable_i             = 1'b0;
    bif.ready_i              = 1'b0;
    bif.opcode_i             = '0;
    bif.instructionAddress_i = '0;
    bif.functionalUnitType_i = '0;
    bif.instMajId_i          = '0;
    bif.instMinId_i          = '0;
    bif.is64Bit_i            = 1'b1;
    bif.instPid_i            = '0;
    bif.instTid_i            = '0;
    bif.instructionBody_i    = '0;
    repeat (3) tick();

    // reset state
    check("rst_valid", 64'(bif.valid_o), 64'd0);
    check("rst_stall", 64'(bif.stall_o), 64'd0);
    check("rst_overflow", 64'(bif.overflow_o), 64'd0);
    check("rst_count", 64'(bif.count_o), 64'd0);
    check("rst_target", bif.target_o, 64'd0);
    check("rst_link", bif.link_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // single op, one-cycle latency, held until ready
    send(1, 64'h100, 14'h00FC, 1'b0, 1'b1, 1'b1, BranchUnitID, 64'h4F0, 64'h104, 1'b1);
    bif.enable_i = 1'b0;
    check("lat_valid", 64'(bif.valid_o), 64'd1);
    check("lat_count", 64'(bif.count_o), 64'd1);
    check("lat_target", bif.target_o, 64'h4F0);
    tick();
    check("hold_valid", 64'(bif.valid_o), 64'd1);
    bif.ready_i = 1'b1;
    tick();
    check("drain1_valid", 64'(bif.valid_o), 64'd0);

    // ready while empty must not underflow
    tick();
    check("empty_ready_count", 64'(bif.count_o), 64'd0);

    // negative displacement, absolute, 32-bit wrap
    send(2, 64'h100, 14'h3FFF, 1'b0, 1'b0, 1'b1, BranchUnitID, 64'hFC, 64'h104, 1'b1);
    send(3, 64'h100, 14'h3FFF, 1'b1, 1'b1, 1'b1, BranchUnitID, 64'hFFFF_FFFF_FFFF_FFFC, 64'h104, 1'b1);
    send(4, 64'hFFFF_FFFC, 14'h0001, 1'b0, 1'b0, 1'b0, BranchUnitID, 64'h0, 64'h0, 1'b1);
    bif.enable_i = 1'b0;
    tick();
    check("drain2_count", 64'(bif.count_o), 64'd0);

    // steady state: one op per cycle, occupancy stays at 1
    for (int i = 0; i < 6; i++) begin
      send(8 + i, 64'h2000 + 64'(i * 8), 14'h0002, 1'b0, 1'(i), 1'b1, BranchUnitID,
           64'h2008 + 64'(i * 8), 64'h2004 + 64'(i * 8), 1'b1);
      check("steady_count", 64'(bif.count_o), 64'd1);
      check("steady_stall", 64'(bif.stall_o), 64'd0);
    end
    bif.enable_i = 1'b0;
    tick();
    check("steady_drain", 64'(bif.count_o), 64'd0);

    // fill to full with ready low, fifth op dropped
    bif.ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(20 + i, 64'h3000, 14'h0010, 1'b0, 1'b1, 1'b1, BranchUnitID, 64'h3040, 64'h3004, 1'b1);
    check("full_stall", 64'(bif.stall_o), 64'd1);
    check("full_count", 64'(bif.count_o), 64'd4);
    check("full_no_ovf", 64'(bif.overflow_o), 64'd0);
    send(24, 64'h3000, 14'h0010, 1'b0, 1'b1, 1'b1, BranchUnitID, 64'h3040, 64'h3004, 1'b0);
    bif.enable_i = 1'b0;
    check("ovf_flag", 64'(bif.overflow_o), 64'd1);
    check("ovf_count", 64'(bif.count_o), 64'd4);
    bif.ready_i = 1'b1;
    repeat (4) tick();
    check("ovf_drain_valid", 64'(bif.valid_o), 64'd0);
    check("ovf_drain_count", 64'(bif.count_o), 64'd0);
    check("ovf_sticky", 64'(bif.overflow_o), 64'd1);

    // full + pop: the same-cycle push is still refused
    bif.ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(30 + i, 64'h4000 + 64'(i * 4), 14'h0000, 1'b0, 1'b0, 1'b1, BranchUnitID,
           64'h4000 + 64'(i * 4), 64'h4004 + 64'(i * 4), 1'b1);
    bif.ready_i = 1'b1;
    send(34, 64'h5000, 14'h0000, 1'b0, 1'b0, 1'b1, BranchUnitID, 64'h5000, 64'h5004, 1'b0);
    bif.enable_i = 1'b0;
    check("full_pop_count", 64'(bif.count_o), 64'd3);
    check("full_pop_stall", 64'(bif.stall_o), 64'd0);
    repeat (3) tick();
    check("full_pop_drain", 64'(bif.count_o), 64'd0);

    // asynchronous reset with three entries queued
    bif.ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      send(40 + i, 64'h6000, 14'h0001, 1'b0, 1'b1, 1'b1, BranchUnitID, 64'h6004, 64'h6004, 1'b1);
    bif.enable_i = 1'b0;
    check("pre_rst_count", 64'(bif.count_o), 64'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 64'(bif.valid_o), 64'd0);
    check("mid_rst_count", 64'(bif.count_o), 64'd0);
    check("mid_rst_overflow", 64'(bif.overflow_o), 64'd0);
    check("mid_rst_target", bif.target_o, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // other unit codes are ignored, even with room available
    send(50, 64'h7000, 14'h0001, 1'b0, 1'b1, 1'b1, FXUnitId, 64'h7004, 64'h7004, 1'b0);
    bif.enable_i = 1'b0;
    check("fx_count", 64'(bif.count_o), 64'd0);
    check("fx_valid", 64'(bif.valid_o), 64'd0);
    check("fx_overflow", 64'(bif.overflow_o), 64'd0);

    // a non-branch op offered while full must not set the flag
    for (int i = 0; i < 4; i++)
      send(60 + i, 64'h8000, 14'h0001, 1'b0, 1'b0, 1'b1, BranchUnitID, 64'h8004, 64'h8004, 1'b1);
    send(64, 64'h8000, 14'h0001, 1'b0, 1'b0, 1'b1, LSUnitId, 64'h8004, 64'h8004, 1'b0);
    bif.enable_i = 1'b0;
    check("ls_full_overflow", 64'(bif.overflow_o), 64'd0);
    bif.ready_i = 1'b1;
    repeat (5) tick();
    check("final_count", 64'(bif.count_o), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
